// File: rtl/reg_bank_if.sv
// ---------------------------------------------------------------------------
// reg_bank_if
//   Bus bundle for the architectural register file.
//
//   master modport (datapath side):
//     reg_write    out  write enable, sampled at the rising edge
//     write_addr   out  destination register from the reg-destination selector
//     write_data   out  data to write
//     read_addr_a  out  read port A address (instruction rs field)
//     read_addr_b  out  read port B address (instruction rt field)
//     dbg_addr     out  debug read address
//     read_data_a  in   contents of register read_addr_a
//     read_data_b  in   contents of register read_addr_b
//     dbg_data     in   contents of register dbg_addr
//     write_count  in   committed writes since reset (wraps at 16 bits)
//
//   slave modport: the register file, directions mirrored.
//
//   There is no valid/ready handshake on this bus: a write is presented for a
//   whole cycle and is taken at the rising edge whenever reg_write is high;
//   reads are plain combinational lookups with no request/acknowledge.
// ---------------------------------------------------------------------------
interface reg_bank_if #(
    parameter int DATA_W = 32
);
    logic              reg_write;
    logic [4:0]        write_addr;
    logic [DATA_W-1:0] write_data;
    logic [4:0]        read_addr_a;
    logic [4:0]        read_addr_b;
    logic [4:0]        dbg_addr;
    logic [DATA_W-1:0] read_data_a;
    logic [DATA_W-1:0] read_data_b;
    logic [DATA_W-1:0] dbg_data;
    logic [15:0]       write_count;

    modport master (
        output reg_write,
        output write_addr,
        output write_data,
        output read_addr_a,
        output read_addr_b,
        output dbg_addr,
        input  read_data_a,
        input  read_data_b,
        input  dbg_data,
        input  write_count
    );

    modport slave (
        input  reg_write,
        input  write_addr,
        input  write_data,
        input  read_addr_a,
        input  read_addr_b,
        input  dbg_addr,
        output read_data_a,
        output read_data_b,
        output dbg_data,
        output write_count
    );
endinterface

// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// reg_bank
//   Architectural register file for the multicycle MIPS datapath.
//   32 general registers of DATA_W bits; r0 has no storage and reads 0.
//   Two combinational read ports (A/B), one combinational debug read port and
//   one clocked write port. A 16-bit counter tracks committed writes.
//
//   Parameters:
//     DATA_W    register width
//     SP_RESET  reset value of r29 ($sp), zero-extended/truncated to DATA_W
//
//   Ports:
//     clk    in  system clock, all state updates on the rising edge
//     reset  in  synchronous active-high reset
//     bus    reg_bank_if.slave  write port, read ports, debug port, counter
//
//   Behaviour notes:
//     - A committed write is reg_write=1 with write_addr!=0 in a non-reset
//       cycle. Writes to r0 are dropped and not counted.
//     - Reads see the registers as they were before the current edge, so a
//       read and a write of the same register in one cycle return the old
//       value (the control FSM depends on this for ALU writeback).
//     - Reset wins over a write presented in the same cycle.
//     - No state machine: the only state is the register array and the
//       write counter.
// ---------------------------------------------------------------------------
module reg_bank #(
    parameter int DATA_W   = 32,
    parameter int SP_RESET = 227
) (
    input logic       clk,
    input logic       reset,
    reg_bank_if.slave bus
);

    localparam logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_RESET);
    localparam int                SP_IDX  = 29;

    // Storage for r1..r31 only; r0 is synthesised as a constant zero.
    logic [DATA_W-1:0] regs [1:31];
    logic [15:0]       count_q;
    logic              commit;

    // A write only counts when it lands in a real register.
    assign commit = bus.reg_write && (bus.write_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                if (i == SP_IDX) begin
                    regs[i] <= SP_INIT;
                end else begin
                    regs[i] <= '0;
                end
            end
            count_q <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (commit && (bus.write_addr == 5'(i))) begin
                    regs[i] <= bus.write_data;
                end
            end
            if (commit) begin
                // Plain modulo-2^16 increment: wraps 0xFFFF -> 0x0000.
                count_q <= count_q + 16'd1;
            end
        end
    end

    // Combinational lookup; address 0 falls through to the zero default.
    function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        for (int i = 1; i < 32; i++) begin
            if (addr == 5'(i)) begin
                val = regs[i];
            end
        end
        return val;
    endfunction

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] rd_dbg;

    always_comb begin
        rd_a   = read_reg(bus.read_addr_a);
        rd_b   = read_reg(bus.read_addr_b);
        rd_dbg = read_reg(bus.dbg_addr);
    end

    assign bus.read_data_a = rd_a;
    assign bus.read_data_b = rd_b;
    assign bus.dbg_data    = rd_dbg;
    assign bus.write_count = count_q;

endmodule

// File: tb/tb_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_reg_bank
//   Self-checking bench for reg_bank. Inputs change on the falling edge;
//   outputs are sampled 1-2 ns after the falling edge, well away from the
//   rising (active) edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_bank;

    localparam int DATA_W = 32;
    localparam logic [31:0] SP_VAL = 32'd227;

    logic clk;
    logic reset;

    int check_cnt = 0;
    int pass_cnt  = 0;

    reg_bank_if #(.DATA_W(DATA_W)) bus ();

    reg_bank #(.DATA_W(DATA_W), .SP_RESET(227)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.reg_write   = 1'b0;
        bus.write_addr  = 5'd0;
        bus.write_data  = '0;
        bus.read_addr_a = 5'd0;
        bus.read_addr_b = 5'd0;
        bus.dbg_addr    = 5'd0;
    endtask

    task automatic do_reset_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        reset          = 1'b1;
        bus.reg_write  = we;
        bus.write_addr = wa;
        bus.write_data = wd;
        @(negedge clk);
        reset         = 1'b0;
        bus.reg_write = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        bus.reg_write  = 1'b1;
        bus.write_addr = wa;
        bus.write_data = wd;
        @(negedge clk);
        bus.reg_write = 1'b0;
    endtask

    // ---------------- vector table ----------------
    // Each row is applied on one falling edge; exp_* are the values seen
    // before the following rising edge (i.e. before this row's write lands).
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    // ---------------- reference model (plain array + counter) ----------------
    logic [31:0] m_regs [32];
    logic [15:0] m_count;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_regs[29] = SP_VAL;
        m_count    = '0;
    endtask

    task automatic model_edge(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (rst) begin
            model_reset();
        end else if (we && wa != 5'd0) begin
            m_regs[wa] = wd;
            m_count    = m_count + 16'd1;
        end
    endtask

    // ---------------- main test ----------------
    initial begin
        reset = 1'b0;
        drive_idle();

        // Reset values: reset cycle carrying a junk write that must be lost.
        do_reset_cycle(1'b1, 5'd29, 32'h55);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.dbg_addr = 5'(i);
            #1;
            check($sformatf("reset_dbg_r%0d", i), bus.dbg_data, (i == 29) ? SP_VAL : 32'd0);
        end
        check("reset_count", 32'(bus.write_count), 32'd0);

        // Table-driven vectors.
        vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8, 5'd29, 32'h0,        SP_VAL,       16'd0};
        vecs[1] = '{1'b1, 5'd31, 32'h12345678, 5'd8, 5'd31, 32'hDEADBEEF, 32'h0,        16'd1};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd8, 5'd31, 32'hDEADBEEF, 32'h12345678, 16'd2};
        vecs[3] = '{1'b0, 5'd5,  32'h999,      5'd0, 5'd31, 32'h0,        32'h12345678, 16'd2};
        vecs[4] = '{1'b1, 5'd5,  32'h11,       5'd0, 5'd5,  32'h0,        32'h0,        16'd2};
        vecs[5] = '{1'b1, 5'd5,  32'h22,       5'd5, 5'd5,  32'h11,       32'h11,       16'd3};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd8,  32'h22,       32'hDEADBEEF, 16'd4};
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            bus.reg_write   = vecs[v].we;
            bus.write_addr  = vecs[v].wa;
            bus.write_data  = vecs[v].wd;
            bus.read_addr_a = vecs[v].ra;
            bus.read_addr_b = vecs[v].rb;
            bus.dbg_addr    = 5'd0;
            #1;
            check($sformatf("vec%0d_a", v), bus.read_data_a, vecs[v].exp_a);
            check($sformatf("vec%0d_b", v), bus.read_data_b, vecs[v].exp_b);
            check($sformatf("vec%0d_cnt", v), 32'(bus.write_count), 32'(vecs[v].exp_cnt));
            check($sformatf("vec%0d_r0", v), bus.dbg_data, 32'd0);
        end
        @(negedge clk);
        drive_idle();

        // Reset vs write in the same cycle.
        do_reset_cycle(1'b1, 5'd29, 32'h55);
        bus.dbg_addr    = 5'd29;
        bus.read_addr_a = 5'd8;
        bus.read_addr_b = 5'd5;
        #1;
        check("rstw_r29", bus.dbg_data, SP_VAL);
        check("rstw_r8_cleared", bus.read_data_a, 32'd0);
        check("rstw_r5_cleared", bus.read_data_b, 32'd0);
        check("rstw_count", 32'(bus.write_count), 32'd0);
        write_reg(5'd29, 32'h55);
        #1;
        check("rstw_r29_after", bus.dbg_data, 32'h55);
        check("rstw_count_after", 32'(bus.write_count), 32'd1);

        // Randomised traffic against the reference model.
        do_reset_cycle(1'b0, 5'd0, 32'd0);
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic        r_rst;
            logic        r_we;
            logic [4:0]  r_wa;
            logic [31:0] r_wd;
            logic [4:0]  r_ra;
            logic [4:0]  r_rb;
            logic [4:0]  r_dbg;
            r_rst = ($urandom_range(0, 49) == 0);
            r_we  = ($urandom_range(0, 3) != 0);
            r_wa  = 5'($urandom_range(0, 31));
            r_wd  = $urandom;
            r_ra  = 5'($urandom_range(0, 31));
            r_rb  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_dbg = ($urandom_range(0, 1) == 0) ? r_ra : 5'($urandom_range(0, 31));
            @(negedge clk);
            reset           = r_rst;
            bus.reg_write   = r_we;
            bus.write_addr  = r_wa;
            bus.write_data  = r_wd;
            bus.read_addr_a = r_ra;
            bus.read_addr_b = r_rb;
            bus.dbg_addr    = r_dbg;
            #1;
            check("rnd_a", bus.read_data_a, m_regs[r_ra]);
            check("rnd_b", bus.read_data_b, m_regs[r_rb]);
            check("rnd_dbg", bus.dbg_data, m_regs[r_dbg]);
            check("rnd_cnt", 32'(bus.write_count), 32'(m_count));
            model_edge(r_rst, r_we, r_wa, r_wd);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_idle();

        // Counter wrap: 65536 committed writes to r1.
        do_reset_cycle(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            bus.reg_write  = 1'b1;
            bus.write_addr = 5'd1;
            bus.write_data = 32'(i);
            if (i == 65535) begin
                #1;
                check("wrap_cnt_ffff", 32'(bus.write_count), 32'h0000FFFF);
            end
        end
        @(negedge clk);
        bus.reg_write = 1'b0;
        bus.dbg_addr  = 5'd1;
        #1;
        check("wrap_cnt_zero", 32'(bus.write_count), 32'd0);
        check("wrap_r1_last", bus.dbg_data, 32'd65535);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
